// File: rtl/softmax_ctrl_pkg.sv
// Shared types and constants for the softmax classifier sequencer.
// Q16.16 format constants and default frame geometry live here.
package softmax_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_FEED,
      ST_GAP,
      ST_WAIT_MAX,
      ST_BP_REQ,
      ST_BP_HOLD,
      ST_DONE
   } state_e;

   localparam int          FRAC_BITS     = 16;
   localparam logic [31:0] ONE           = 32'h0001_0000;
   localparam int          DEF_N_CLASSES = 4;
   localparam int          DEF_IDX_W     = 3;

endpackage

// File: rtl/softmax_ctrl_rst_sync.sv
// sm_rst generator: asserts asynchronously with rst_n, releases two clocks later,
// and emits a one-cycle pulse whenever abort_i is sampled high.
module softmax_ctrl_rst_sync
   import softmax_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic abort_i,
   output logic sm_rst_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0] | abort_i, 1'b0};
      end
   end

   assign sm_rst_o = sync_q[1];

endmodule

// File: rtl/softmax_ctrl.sv
// Softmax classifier sequencer: buffers a logit frame, feeds it to the softmax,
// captures the argmax, then drains the backprop error terms. Optional watchdog: SOFTMAX_CTRL_TIMEOUT_EN.
module softmax_ctrl
   import softmax_ctrl_pkg::*;
#(
   parameter int N_CLASSES   = DEF_N_CLASSES,
   parameter int IDX_W       = DEF_IDX_W,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic signed [DATA_W-1:0] s_data,
   input  logic                     s_last,
   input  logic [IDX_W-1:0]         s_label,
   output logic                     sm_rst,
   output logic                     sm_start,
   output logic                     sm_backprop_ctrl,
   output logic signed [DATA_W-1:0] sm_input,
   output logic [IDX_W-1:0]         sm_input_idx,
   output logic [IDX_W-1:0]         sm_expected_label,
   input  logic                     sm_in_ready,
   input  logic [IDX_W-1:0]         sm_max,
   input  logic                     sm_max_ready,
   input  logic                     sm_out_ready,
   input  logic [IDX_W-1:0]         sm_out_idx,
   input  logic signed [DATA_W-1:0] sm_out_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic signed [DATA_W-1:0] m_data,
   output logic [IDX_W-1:0]         m_idx,
   output logic                     m_last,
   output logic [IDX_W-1:0]         pred,
   output logic                     pred_valid,
   output logic                     correct,
   output logic                     frame_err,
   output logic                     busy
);

   localparam int                 AW       = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_CLASSES - 1);

   if (N_CLASSES < 2 || (1 << IDX_W) <= N_CLASSES || TIMEOUT_CYC < 1) begin : g_param_chk
      $error("softmax_ctrl: illegal N_CLASSES/IDX_W/TIMEOUT_CYC combination");
   end

   state_e                   state_q;
   logic [IDX_W-1:0]         cnt_q, cnt_nxt, label_q;
   logic signed [DATA_W-1:0] buf_q [0:(1<<AW)-1];
   logic signed [DATA_W-1:0] sm_input_q, m_data_q;
   logic [IDX_W-1:0]         sm_input_idx_q, m_idx_q, pred_q;
   logic                     s_ready_q, sm_start_q, bp_q, m_valid_q, m_last_q;
   logic                     pred_valid_q, correct_q, frame_err_q, max_prev_q;
   logic                     s_fire, abort;

   assign s_fire  = s_valid && s_ready_q;
   assign cnt_nxt = cnt_q + IDX_W'(1);

   // Logit buffer carries no reset; contents are don't-care between frames.
   always_ff @(posedge clk) begin
      if (s_fire) begin
         buf_q[cnt_q[AW-1:0]] <= s_data;
      end
   end

`ifdef SOFTMAX_CTRL_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_q, tmo_elapsed;
   state_e           tmo_state_q;
   logic             tmo_active;

   assign tmo_active  = (state_q == ST_WAIT_MAX) || (state_q == ST_BP_REQ);
   assign tmo_elapsed = (state_q != tmo_state_q) ? '0 : tmo_q;
   assign abort       = tmo_active && (tmo_elapsed == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q       <= '0;
         tmo_state_q <= ST_IDLE;
      end else begin
         tmo_state_q <= state_q;
         tmo_q       <= tmo_active ? tmo_elapsed + TMO_W'(1) : '0;
      end
   end
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         label_q        <= '0;
         s_ready_q      <= 1'b0;
         sm_start_q     <= 1'b0;
         bp_q           <= 1'b0;
         sm_input_q     <= '0;
         sm_input_idx_q <= '0;
         m_valid_q      <= 1'b0;
         m_data_q       <= '0;
         m_idx_q        <= '0;
         m_last_q       <= 1'b0;
         pred_q         <= '0;
         pred_valid_q   <= 1'b0;
         correct_q      <= 1'b0;
         frame_err_q    <= 1'b0;
         max_prev_q     <= 1'b0;
      end else begin
         pred_valid_q <= 1'b0;
         correct_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         max_prev_q   <= sm_max_ready;
         if (abort) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            s_ready_q   <= 1'b1;
            sm_start_q  <= 1'b0;
            bp_q        <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            frame_err_q <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  s_ready_q <= 1'b1;
                  if (s_fire) begin
                     label_q <= s_label;
                     if (s_last) begin
                        frame_err_q <= 1'b1;
                     end else begin
                        cnt_q   <= IDX_W'(1);
                        state_q <= ST_FILL;
                     end
                  end
               end
               ST_FILL: begin
                  if (s_fire) begin
                     if (cnt_q == LAST_IDX) begin
                        // Frame length is fixed; a missing s_last is flagged but tolerated.
                        frame_err_q    <= !s_last;
                        s_ready_q      <= 1'b0;
                        cnt_q          <= '0;
                        sm_input_q     <= buf_q[0];
                        sm_input_idx_q <= '0;
                        sm_start_q     <= sm_in_ready;
                        state_q        <= ST_FEED;
                     end else if (s_last) begin
                        frame_err_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ST_IDLE;
                     end else begin
                        cnt_q <= cnt_nxt;
                     end
                  end
               end
               ST_FEED: begin
                  if (sm_start_q && sm_in_ready && !bp_q) begin
                     sm_start_q <= 1'b0;
                     if (cnt_q == LAST_IDX) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_MAX;
                     end else begin
                        cnt_q          <= cnt_nxt;
                        sm_input_q     <= buf_q[cnt_nxt[AW-1:0]];
                        sm_input_idx_q <= cnt_nxt;
                        state_q        <= ST_GAP;
                     end
                  end else begin
                     sm_start_q <= sm_in_ready;
                  end
               end
               ST_GAP: begin
                  sm_start_q <= sm_in_ready;
                  state_q    <= ST_FEED;
               end
               ST_WAIT_MAX: begin
                  if (sm_max_ready && !max_prev_q) begin
                     pred_q       <= sm_max;
                     pred_valid_q <= 1'b1;
                     correct_q    <= (sm_max == label_q);
                     bp_q         <= 1'b1;
                     sm_start_q   <= 1'b0;
                     state_q      <= ST_BP_REQ;
                  end
               end
               ST_BP_REQ: begin
                  if (sm_start_q && sm_out_ready) begin
                     m_data_q   <= sm_out_data;
                     m_idx_q    <= sm_out_idx;
                     m_valid_q  <= 1'b1;
                     m_last_q   <= (sm_out_idx == LAST_IDX);
                     sm_start_q <= 1'b0;
                     state_q    <= ST_BP_HOLD;
                  end else begin
                     sm_start_q <= sm_out_ready && !m_valid_q;
                  end
               end
               ST_BP_HOLD: begin
                  if (m_valid_q && m_ready) begin
                     m_valid_q <= 1'b0;
                     m_last_q  <= 1'b0;
                     if (m_last_q) begin
                        bp_q    <= 1'b0;
                        state_q <= ST_DONE;
                     end else begin
                        state_q <= ST_BP_REQ;
                     end
                  end
               end
               ST_DONE: begin
                  s_ready_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   softmax_ctrl_rst_sync u_rst_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .abort_i  (abort),
      .sm_rst_o (sm_rst)
   );

   assign s_ready           = s_ready_q;
   assign sm_start          = sm_start_q;
   assign sm_backprop_ctrl  = bp_q;
   assign sm_input          = sm_input_q;
   assign sm_input_idx      = sm_input_idx_q;
   assign sm_expected_label = label_q;
   assign m_valid           = m_valid_q;
   assign m_data            = m_data_q;
   assign m_idx             = m_idx_q;
   assign m_last            = m_last_q;
   assign pred              = pred_q;
   assign pred_valid        = pred_valid_q;
   assign correct           = correct_q;
   assign frame_err         = frame_err_q;
   assign busy              = (state_q != ST_IDLE);

endmodule

// File: doc/softmax_ctrl.md
Name: softmax_ctrl

Overview:
- Sequencer for the softmax classifier stage (N_CLASSES logits, Q16.16 fixed point).
- Buffers one logit frame from the upstream layer and feeds it element by element using the softmax start/in_ready handshake.
- Waits for the argmax result, then switches the softmax into backprop mode and drains N_CLASSES error terms to the backprop path.
- Reports prediction, correctness and frame statistics.

Parameters:
- N_CLASSES, 4, number of logits per frame (>=2)
- IDX_W, 3, class index width; must satisfy 2**IDX_W > N_CLASSES
- DATA_W, 32, logit/error width (Q16.16)
- TIMEOUT_CYC, 1024, watchdog limit; used only with the optional feature

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  upstream logit valid
- s_ready  out  1  upstream logit ready
- s_data  in  DATA_W  logit value
- s_last  in  1  marks last logit of frame
- s_label  in  IDX_W  expected label; sampled with the first logit of the frame
- sm_rst  out  1  active-high reset to softmax
- sm_start  out  1  softmax start strobe
- sm_backprop_ctrl  out  1  softmax mode: 0 forward, 1 backprop
- sm_input  out  DATA_W  softmax sf_input
- sm_input_idx  out  IDX_W  softmax sf_input_idx
- sm_expected_label  out  IDX_W  latched label
- sm_in_ready  in  1  softmax ready for forward element
- sm_max  in  IDX_W  softmax argmax
- sm_max_ready  in  1  argmax valid (level)
- sm_out_ready  in  1  softmax error element ready
- sm_out_idx  in  IDX_W  error element index
- sm_out_data  in  DATA_W  error element value
- m_valid  out  1  error term valid to backprop
- m_ready  in  1  backprop accepts
- m_data  out  DATA_W  error term
- m_idx  out  IDX_W  error term index
- m_last  out  1  final error term of frame
- pred  out  IDX_W  last prediction
- pred_valid  out  1  one-cycle pulse when pred updates
- correct  out  1  valid with pred_valid: pred == label
- frame_err  out  1  one-cycle pulse on malformed frame
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0, except sm_rst = 1. sm_rst is asserted asynchronously and deasserts 2 clk after rst_n rises. State returns to IDLE and the buffer contents are don't-care.
- States: IDLE, FILL, FEED, GAP, WAIT_MAX, BP_REQ, BP_HOLD, DONE.
- IDLE:
  - s_ready = 1.
  - First s_valid&&s_ready writes buf[0], latches s_label, then the state goes to FILL. If that beat carries s_last and N_CLASSES > 1, this is an early s_last (see FILL).
- FILL:
  - s_ready = 1 and each transfer writes buf[k].
  - s_last at k < N-1: frame_err pulse, frame discarded, state goes to IDLE.
  - At k = N-1: frame ends whether or not s_last is set. A missing s_last also pulses frame_err, but the frame still proceeds to FEED.
  - s_ready = 0 from then until DONE.
- FEED:
  - sm_input = buf[i] and sm_input_idx = i are stable.
  - sm_start = 1 while sm_in_ready = 1.
  - An element transfers on an edge with sm_start && sm_in_ready && !sm_backprop_ctrl. Then sm_start drops, the state goes to GAP for exactly 1 cycle (start low), and i increments.
  - After i = N-1 transfers, the state goes to WAIT_MAX.
- WAIT_MAX:
  - Detects the rising edge of sm_max_ready (registered previous value).
  - On the edge: pred <= sm_max, pred_valid and correct pulse the next cycle, sm_backprop_ctrl <= 1, sm_start <= 0, state goes to BP_REQ.
- BP_REQ:
  - When sm_out_ready = 1 and m_valid = 0, assert sm_start.
  - On an edge with sm_start && sm_out_ready: capture sm_out_data/sm_out_idx into m_data/m_idx, set m_valid, and set m_last = (sm_out_idx == N-1). Then drop sm_start and go to BP_HOLD.
- BP_HOLD:
  - Hold m_* until m_valid && m_ready.
  - If the accepted beat had m_last, clear sm_backprop_ctrl and go to DONE; otherwise go to BP_REQ.
  - The next sm_start is never raised while m_valid = 1.
- DONE: 1 cycle, then IDLE. The earliest new frame is accepted one cycle later.
- Latency: buffer to softmax is 2 cycles per element minimum (start + gap). m_valid is 1 cycle after capture.
- sm_expected_label is driven from the latched label for the whole frame.
- An out-of-order sm_out_idx is passed through unchanged. Only idx == N-1 ends the frame.
- A sm_max_ready already high on WAIT_MAX entry is not an edge; the controller waits for a fresh rise.

Optional Feature:
- SOFTMAX_CTRL_TIMEOUT_EN defined:
  - A counter runs in WAIT_MAX and BP_REQ and clears on each state change.
  - Reaching TIMEOUT_CYC triggers an abort: frame_err pulse, 1-cycle sm_rst pulse, sm_backprop_ctrl = 0, m_valid cleared, state goes to IDLE.
- Undefined: no counter; the controller waits indefinitely.

Decomposition:
- Shared package holds:
  - state enum
  - Q16.16 format constants (FRAC_BITS = 16, ONE = 32'h0001_0000)
  - default N_CLASSES/IDX_W
- One sub-module, softmax_ctrl_rst_sync: 2-flop async-assert/sync-deassert generator for sm_rst, with an abort-pulse input.

Test Plan:
- Reset with rst_n = 0 mid-FEED → all outputs 0 immediately, sm_rst = 1, deasserts 2 clk after release. The next frame runs clean.
- Frame 0x8000, 0x10F00, 0x19E00, 0x22D00, label 3; model argmax = 3 → 4 start transfers with idx 0..3, each start separated by a low cycle. pred = 3, correct = 1, sm_backprop_ctrl rises.
- Same frame, label 0 → correct = 0. Error terms idx 0..3 appear on m_* in order with m_last only on idx 3, after which sm_backprop_ctrl falls.
- m_ready held 0 for 10 cycles on idx 1 → m_data stable, sm_start stays 0, no error term lost.
- s_last on the 2nd logit → frame_err pulse, no sm_start, busy falls. A 4-logit frame without s_last → frame_err pulse and the frame still completes.
- With SOFTMAX_CTRL_TIMEOUT_EN and TIMEOUT_CYC = 16, sm_max_ready never rises → abort at cycle 16 of WAIT_MAX with frame_err and sm_rst pulses, state returns to IDLE.
